// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and GF(2^8) / round-key index helpers
// for the AES key schedule and its S-box.
package aes_pkg;

  localparam logic [3:0]  NR_128    = 4'd10;
  localparam logic [3:0]  NR_192    = 4'd12;
  localparam logic [3:0]  NR_256    = 4'd14;
  localparam int unsigned MAX_WORDS = 60;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_READY
  } ks_state_e;

  // Multiply by x in GF(2^8) with the AES polynomial; also the rcon step.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic nr_legal(input logic [3:0] nr);
    return (nr == NR_128) || (nr == NR_192) || (nr == NR_256);
  endfunction

  // First word index of round key a.
  function automatic logic [5:0] rk_base(input logic [3:0] a);
    return {a, 2'b00};
  endfunction

  // Word count that must exist before round key a is complete.
  function automatic logic [6:0] rk_need(input logic [3:0] a);
    return {1'b0, a, 2'b00} + 7'd4;
  endfunction

  // Total words in the expanded schedule, 4*(nr+1).
  function automatic logic [5:0] total_words(input logic [3:0] nr);
    return {nr, 2'b00} + 6'd4;
  endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Key-load and round-key lookup bus between the loader/Encrypt_Core (master)
// and the key schedule (slave).
//  key_start/key_in/nr : key load request
//  addr / key_out      : round-key lookup, key_out = {valid, round_key}
//  key_busy/key_done/key_err : schedule status
interface aes_key_schedule_if;
  logic         key_start;
  logic [255:0] key_in;
  logic [3:0]   nr;
  logic [3:0]   addr;
  logic [128:0] key_out;
  logic         key_busy;
  logic         key_done;
  logic         key_err;

  modport master (
    output key_start, key_in, nr, addr,
    input  key_out, key_busy, key_done, key_err
  );

  modport slave (
    input  key_start, key_in, nr, addr,
    output key_out, key_busy, key_done, key_err
  );
endinterface

// File: rtl/aes_key_schedule_subword.sv
// SubWord: S-box applied to each byte of a 32-bit word.
//  din  : word in
//  dout : substituted word
module aes_subword (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (din[8*g +: 8]),
      .s (dout[8*g +: 8])
    );
  end
endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) (as x^254) followed
// by the FIPS-197 affine transform.
//  a : input byte
//  s : substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);
  logic [7:0] x3, x7, x15, x31, x63, x127, inv;

  always_comb begin
    // Addition chain for x^254; 0 maps to 0 as required.
    x3   = gf_mul(gf_mul(a, a), a);
    x7   = gf_mul(gf_mul(x3, x3), a);
    x15  = gf_mul(gf_mul(x7, x7), a);
    x31  = gf_mul(gf_mul(x15, x15), a);
    x63  = gf_mul(gf_mul(x31, x31), a);
    x127 = gf_mul(gf_mul(x63, x63), a);
    inv  = gf_mul(x127, x127);
    s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

// File: rtl/aes_key_schedule.sv
// Word-serial AES key expansion (128/192/256) serving round keys by index
// on a {valid, key} lookup bus; keys become valid as soon as their four
// words exist, so encryption overlaps expansion.
//  clk, rst_n : clock, asynchronous active-low reset
//  kif        : slave side of aes_key_schedule_if (load, lookup, status)
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  aes_key_schedule_if.slave kif
);
  ks_state_e   state, state_next;
  logic [31:0] w [MAX_WORDS];
  logic [5:0]  wcnt;
  logic [3:0]  nr_r, nk_r;
  logic [2:0]  mod_cnt;   // wcnt mod Nk
  logic [7:0]  rcon;
  logic        key_done_r, key_err_r;

  logic        start_req, start_ok, start_bad, last;
  logic [7:0]  key_word_en;
  logic [31:0] prev_w, far_w, sub_in, sub_out, t_w;
  logic        in_range, valid;
  logic [5:0]  base;

  always_comb begin
    start_req = kif.key_start && (state != S_EXPAND);
    start_ok  = start_req && nr_legal(kif.nr);
    start_bad = start_req && !nr_legal(kif.nr);
    last      = (wcnt + 6'd1) == total_words(nr_r);
    key_word_en = (kif.nr == NR_128) ? 8'h0f : (kif.nr == NR_192) ? 8'h3f : 8'hff;
  end

  // Expansion datapath: w[i] = w[i-Nk] ^ f(w[i-1]).
  always_comb begin
    prev_w = w[wcnt - 6'd1];
    far_w  = w[wcnt - {2'b00, nk_r}];
    sub_in = (mod_cnt == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    if (mod_cnt == 3'd0)
      t_w = sub_out ^ {rcon, 24'h0};
    else if ((nk_r == 4'd8) && (mod_cnt == 3'd4))
      t_w = sub_out;
    else
      t_w = prev_w;
  end

  aes_subword u_subword (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_READY: begin
        if (start_ok)       state_next = S_EXPAND;
        else if (start_bad) state_next = S_IDLE;
      end
      S_EXPAND: if (last) state_next = S_READY;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt       <= '0;
      nr_r       <= '0;
      nk_r       <= '0;
      mod_cnt    <= '0;
      rcon       <= '0;
      key_done_r <= 1'b0;
      key_err_r  <= 1'b0;
    end else begin
      key_done_r <= 1'b0;
      if (start_ok) begin
        key_err_r <= 1'b0;
        nr_r      <= kif.nr;
        nk_r      <= kif.nr - 4'd6;
        wcnt      <= {2'b00, kif.nr - 4'd6};
        rcon      <= 8'h01;
        mod_cnt   <= '0;
      end else if (start_bad) begin
        key_err_r <= 1'b1;
        nr_r      <= '0;
        nk_r      <= '0;
        wcnt      <= '0;
      end else if (state == S_EXPAND) begin
        wcnt    <= wcnt + 6'd1;
        mod_cnt <= ({1'b0, mod_cnt} == nk_r - 4'd1) ? '0 : mod_cnt + 3'd1;
        if (mod_cnt == 3'd0) rcon <= xtime(rcon);
        if (last) key_done_r <= 1'b1;
      end
    end
  end

  // Word store: cipher key words on a legal start, one expanded word per cycle.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      for (int unsigned j = 0; j < 8; j++)
        if (key_word_en[j]) w[j] <= kif.key_in[255 - 32*j -: 32];
    end else if (state == S_EXPAND) begin
      w[wcnt] <= far_w ^ t_w;
    end
  end

  always_comb begin
    in_range = kif.addr <= nr_r;
    valid    = (state != S_IDLE) && in_range && ({1'b0, wcnt} >= rk_need(kif.addr));
    base     = in_range ? rk_base(kif.addr) : '0;
    kif.key_out  = valid ? {1'b1, w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]}
                         : '0;
    kif.key_busy = (state == S_EXPAND);
    kif.key_done = key_done_r;
    kif.key_err  = key_err_r;
  end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule with FIPS-197 key vectors.
module tb_aes_key_schedule;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'hdeadbeefcafef00d5a5a5a5aa5a5a5a5};
  localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KA1   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

  aes_key_schedule_if kif ();

  aes_key_schedule dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [3:0] a);
    kif.addr = a;
    #1;
  endtask

  task automatic start_key(input logic [255:0] k, input logic [3:0] n);
    kif.key_in    = k;
    kif.nr        = n;
    kif.key_start = 1'b1;
    tick();
    kif.key_start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int c_out);
    c_out = -1;
    for (int c = 1; c <= max; c++) begin
      tick();
      if (kif.key_done === 1'b1) begin
        c_out = c;
        break;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    kif.key_start = 1'b0;
    kif.key_in    = '0;
    kif.nr        = '0;
    kif.addr      = '0;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_busy",  kif.key_busy, 0);
    check("rst_done",  kif.key_done, 0);
    check("rst_err",   kif.key_err, 0);
    check("rst_valid", kif.key_out[128], 0);
    rst_n = 1'b1;
    tick();

    // AES-128 with overlap observation, cycle by cycle
    start_key(K128, 4'd10);
    peek(4'd0);
    check("ovl_a0_first", kif.key_out, {1'b1, 128'h000102030405060708090a0b0c0d0e0f});
    for (int k = 1; k <= 40; k++) begin
      tick();
      peek(4'd2);
      check("ovl_a2_valid", kif.key_out[128], (4 + k >= 12));
      peek(4'd11);
      check("ovl_a11_valid", kif.key_out[128], 0);
      check("done_timing", kif.key_done, (k == 40));
      check("busy_timing", kif.key_busy, (k < 40));
    end
    tick();
    check("done_pulse", kif.key_done, 0);
    peek(4'd1);
    check("k128_r1", kif.key_out, {1'b1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe});
    peek(4'd10);
    check("k128_r10", kif.key_out, {1'b1, 128'h13111d7fe3944a17f307a78b4d2b30c5});
    peek(4'd11);
    check("k128_r11", kif.key_out, 0);

    // AES-192
    start_key(K192, 4'd12);
    wait_done(100, cyc);
    check("k192_cycles", cyc, 46);
    peek(4'd12);
    check("k192_r12", kif.key_out, {1'b1, 128'ha4970a331a78dc09c418c271e3a41d5d});
    peek(4'd13);
    check("k192_r13", kif.key_out, 0);

    // Restart from READY with AES-256: old keys must vanish at once
    start_key(K256, 4'd14);
    peek(4'd12);
    check("restart_r12", kif.key_out[128], 0);
    peek(4'd2);
    check("restart_r2", kif.key_out[128], 0);
    peek(4'd1);
    check("restart_r1", kif.key_out, {1'b1, 128'h101112131415161718191a1b1c1d1e1f});
    wait_done(100, cyc);
    check("k256_cycles", cyc, 52);
    peek(4'd14);
    check("k256_r14", kif.key_out, {1'b1, 128'h24fc79ccbf0979e9371ac23c6d68de36});
    peek(4'd15);
    check("k256_r15", kif.key_out, 0);

    // Illegal round count
    start_key(K128, 4'd9);
    check("bad_err", kif.key_err, 1);
    check("bad_busy", kif.key_busy, 0);
    for (int a = 0; a < 16; a++) begin
      peek(4'(a));
      check("bad_valid", kif.key_out[128], 0);
    end
    tick();
    tick();
    peek(4'd0);
    check("bad_valid_later", kif.key_out[128], 0);
    check("bad_err_sticky", kif.key_err, 1);

    // Legal start clears the error; a start mid-expansion is ignored
    start_key(KA1, 4'd10);
    check("err_cleared", kif.key_err, 0);
    repeat (5) tick();
    start_key(K128, 4'd14);
    wait_done(100, cyc);
    check("ignored_cycles", cyc, 34);
    peek(4'd1);
    check("a1_r1", kif.key_out, {1'b1, 128'ha0fafe1788542cb123a339392a6c7605});
    peek(4'd10);
    check("a1_r10", kif.key_out, {1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    peek(4'd14);
    check("a1_r14", kif.key_out, 0);

    // Reset in the middle of an expansion
    start_key(K256, 4'd14);
    repeat (19) tick();
    rst_n = 1'b0;
    peek(4'd0);
    check("mid_rst_busy",  kif.key_busy, 0);
    check("mid_rst_done",  kif.key_done, 0);
    check("mid_rst_err",   kif.key_err, 0);
    check("mid_rst_out",   kif.key_out, 0);
    tick();
    rst_n = 1'b1;
    tick();
    peek(4'd0);
    check("post_rst_valid", kif.key_out[128], 0);
    start_key(K128, 4'd10);
    wait_done(100, cyc);
    check("post_rst_cycles", cyc, 40);
    peek(4'd10);
    check("post_rst_r10", kif.key_out, {1'b1, 128'h13111d7fe3944a17f307a78b4d2b30c5});
    peek(4'd0);
    check("post_rst_r0", kif.key_out, {1'b1, 128'h000102030405060708090a0b0c0d0e0f});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
